// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the writeback / register-file slice.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 16;

  typedef logic [DEF_DATA_W-1:0]           word_t;
  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_idx_t;

  typedef enum logic {
    WB_RESULT = 1'b0,
    WB_BRANCH = 1'b1
  } wb_sel_e;

  // True when an index names a physically present register. This matters only when
  // NUM_REGS is not a power of two.
  function automatic logic idx_in_range(input int unsigned idx, input int unsigned num);
    return idx < num;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with an optional write-through path.
// Register 0 reads as zero when ZERO_REG is set. Out-of-range indices read as zero.
module regfile_rd_port
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic              byp_en,
  input  logic [AW-1:0]     byp_idx,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rdata
);

  // Resolve the read: hardwired zero, then bypass, then array contents.
  always_comb begin
    rdata = '0;
    if (idx_in_range(32'(addr), NUM_REGS) && !(ZERO_REG != 0 && addr == '0)) begin
      if (byp_en && byp_idx == addr) begin
        rdata = byp_data;
      end else begin
        rdata = regs[addr];
      end
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: commits MEM/WB results into the architectural register file, serves two
// decode read ports and one debug port, and counts commits.
// Build option: define WB_BYPASS_EN to forward the value being committed this cycle onto
// Rd1/Rd2. DbgData always shows the array contents.
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Result,
  input  logic [DATA_W-1:0] BranchRes,
  input  logic [AW-1:0]     RdWb,
  input  logic              Wrenable,
  input  logic              WbSel,
  input  logic [AW-1:0]     Ra1,
  input  logic [AW-1:0]     Ra2,
  output logic [DATA_W-1:0] Rd1,
  output logic [DATA_W-1:0] Rd2,
  input  logic [AW-1:0]     DbgAddr,
  output logic [DATA_W-1:0] DbgData,
  output logic [CNT_W-1:0]  CommitCnt,
  output logic              WbBusy
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              wr_array;
  logic              byp_en;

  assign wdata = (wb_sel_e'(WbSel) == WB_BRANCH) ? BranchRes : Result;

  // Writes to register 0 (when hardwired) or past the array are dropped but still count.
  assign wr_array = Wrenable && idx_in_range(32'(RdWb), NUM_REGS) &&
                    !(ZERO_REG != 0 && RdWb == '0);

`ifdef WB_BYPASS_EN
  assign byp_en = Wrenable;
`else
  assign byp_en = 1'b0;
`endif

  // Register array: reset clears everything and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_array) begin
      regs_q[RdWb] <= wdata;
    end
  end

  // Commit counter and busy hint; the counter wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (Wrenable) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      busy_q <= Wrenable;
    end
  end

  assign CommitCnt = cnt_q;
  assign WbBusy    = busy_q;

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_rd1 (
    .addr     (Ra1),
    .regs     (regs_q),
    .byp_en   (byp_en),
    .byp_idx  (RdWb),
    .byp_data (wdata),
    .rdata    (Rd1)
  );

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_rd2 (
    .addr     (Ra2),
    .regs     (regs_q),
    .byp_en   (byp_en),
    .byp_idx  (RdWb),
    .byp_data (wdata),
    .rdata    (Rd2)
  );

  // Debug port never forwards the in-flight write.
  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_dbg (
    .addr     (DbgAddr),
    .regs     (regs_q),
    .byp_en   (1'b0),
    .byp_idx  (RdWb),
    .byp_data (wdata),
    .rdata    (DbgData)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed plus random checks of wb_regfile against a behavioural model.
// A second instance with a 4-bit commit counter covers counter wrap.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Result, BranchRes;
  logic [3:0]  RdWb, Ra1, Ra2, DbgAddr;
  logic        Wrenable, WbSel;
  logic [31:0] Rd1, Rd2, DbgData;
  logic [15:0] CommitCnt;
  logic        WbBusy;
  logic [31:0] c4_rd1, c4_rd2, c4_dbg;
  logic [3:0]  c4_cnt;
  logic        c4_busy;

  // Model state.
  logic [31:0] m [16];
  int unsigned mcnt;
  logic        mbusy;

  int unsigned vecs = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .Result(Result), .BranchRes(BranchRes), .RdWb(RdWb),
    .Wrenable(Wrenable), .WbSel(WbSel), .Ra1(Ra1), .Ra2(Ra2), .Rd1(Rd1), .Rd2(Rd2),
    .DbgAddr(DbgAddr), .DbgData(DbgData), .CommitCnt(CommitCnt), .WbBusy(WbBusy)
  );

  wb_regfile #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .Result(Result), .BranchRes(BranchRes), .RdWb(RdWb),
    .Wrenable(Wrenable), .WbSel(WbSel), .Ra1(Ra1), .Ra2(Ra2), .Rd1(c4_rd1), .Rd2(c4_rd2),
    .DbgAddr(DbgAddr), .DbgData(c4_dbg), .CommitCnt(c4_cnt), .WbBusy(c4_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value from the register model and the current write inputs.
  function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
    logic [31:0] wd;
    wd = WbSel ? BranchRes : Result;
    if (a == 4'd0) return 32'h0;
    if (byp && Wrenable && RdWb == a) return wd;
    return m[a];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rd1"}, Rd1, exp_rd(Ra1, BYP));
    chk({tag, ".rd2"}, Rd2, exp_rd(Ra2, BYP));
    chk({tag, ".dbg"}, DbgData, exp_rd(DbgAddr, 1'b0));
    chk({tag, ".cnt"}, {16'h0, CommitCnt}, mcnt & 32'hFFFF);
    chk({tag, ".cnt4"}, {28'h0, c4_cnt}, mcnt & 32'hF);
    chk({tag, ".busy"}, {31'h0, WbBusy}, {31'h0, mbusy});
  endtask

  // Advance one clock and apply the architectural effect of the sampled inputs.
  task automatic tick();
    logic [31:0] wd;
    @(posedge clk);
    wd = WbSel ? BranchRes : Result;
    if (rst) begin
      foreach (m[i]) m[i] = 32'h0;
      mcnt  = 0;
      mbusy = 1'b0;
    end else begin
      mbusy = Wrenable;
      if (Wrenable) begin
        mcnt++;
        if (RdWb != 4'd0) m[RdWb] = wd;
      end
    end
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [3:0] idx, input logic sel,
                        input logic [31:0] res, input logic [31:0] br);
    Wrenable = en; RdWb = idx; WbSel = sel; Result = res; BranchRes = br;
  endtask

  initial begin
    foreach (m[i]) m[i] = 32'h0;
    mcnt = 0; mbusy = 1'b0;
    set_wr(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    Ra1 = 4'd0; Ra2 = 4'd0; DbgAddr = 4'd0;

    // Reset for two cycles, then scan every index.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      Ra1 = 4'(i); Ra2 = 4'(15 - i); DbgAddr = 4'(i);
      #1;
      check_all("reset_scan");
    end
    chk("reset.cnt", {16'h0, CommitCnt}, 32'h0);
    chk("reset.busy", {31'h0, WbBusy}, 32'h0);

    // Plain commit of Result to r5.
    set_wr(1'b1, 4'd5, 1'b0, 32'hDEADBEEF, 32'h11111111);
    tick();
    set_wr(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    Ra1 = 4'd5; Ra2 = 4'd0; DbgAddr = 4'd5;
    #1;
    chk("wr5.rd1", Rd1, 32'hDEADBEEF);
    chk("wr5.cnt", {16'h0, CommitCnt}, 32'd1);
    chk("wr5.busy", {31'h0, WbBusy}, 32'd1);
    check_all("wr5");

    // BranchRes commit to r3 read on both ports in the same cycle.
    set_wr(1'b1, 4'd3, 1'b1, 32'h99999999, 32'h00000040);
    Ra1 = 4'd3; Ra2 = 4'd3; DbgAddr = 4'd3;
    #1;
    chk("same_cyc.rd1", Rd1, BYP ? 32'h40 : 32'h0);
    chk("same_cyc.rd2", Rd2, BYP ? 32'h40 : 32'h0);
    chk("same_cyc.dbg", DbgData, 32'h0);
    tick();
    set_wr(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("next_cyc.rd1", Rd1, 32'h40);
    chk("next_cyc.rd2", Rd2, 32'h40);
    check_all("next_cyc");

    // Write to hardwired r0: array untouched but counted.
    set_wr(1'b1, 4'd0, 1'b0, 32'h1234, 32'h0);
    Ra1 = 4'd0; Ra2 = 4'd5; DbgAddr = 4'd0;
    #1;
    chk("r0_same.rd1", Rd1, 32'h0);
    tick();
    set_wr(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("r0.rd1", Rd1, 32'h0);
    chk("r0.dbg", DbgData, 32'h0);
    chk("r0.cnt", {16'h0, CommitCnt}, 32'd3);
    chk("r0.busy", {31'h0, WbBusy}, 32'd1);
    check_all("r0");

    // Put data in r7, then collide a write with reset.
    set_wr(1'b1, 4'd7, 1'b0, 32'hAA, 32'h0);
    tick();
    rst = 1'b1;
    set_wr(1'b1, 4'd7, 1'b0, 32'hFF, 32'h0);
    tick();
    rst = 1'b0;
    set_wr(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    Ra1 = 4'd7; Ra2 = 4'd5; DbgAddr = 4'd7;
    #1;
    chk("rst_wr.rd1", Rd1, 32'h0);
    chk("rst_wr.dbg", DbgData, 32'h0);
    chk("rst_wr.cnt", {16'h0, CommitCnt}, 32'h0);
    chk("rst_wr.busy", {31'h0, WbBusy}, 32'h0);

    // 17 commits from reset: 4-bit counter goes 1..15, 0, 1.
    for (int k = 1; k <= 17; k++) begin
      set_wr(1'b1, 4'(k), 1'b0, 32'(k * 3), 32'h0);
      tick();
      #1;
      chk("wrap.cnt4", {28'h0, c4_cnt}, 32'(k % 16));
      chk("wrap.cnt", {16'h0, CommitCnt}, 32'(k));
    end
    set_wr(1'b0, 4'd0, 1'b0, 32'h0, 32'h0);
    tick();

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_wr(1'($urandom_range(0, 2) != 0), 4'($urandom), 1'($urandom),
             $urandom, $urandom);
      Ra1 = ($urandom_range(0, 3) == 0) ? RdWb : 4'($urandom);
      Ra2 = ($urandom_range(0, 3) == 0) ? RdWb : 4'($urandom);
      DbgAddr = 4'($urandom);
      #1;
      check_all("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
